// File: rtl/softmax_div_feeder_pkg.sv
// Shared state type, Q2.13 format constants and width helpers for the softmax divider feeder.
package softmax_pkg;

  typedef enum logic [1:0] {StLoad, StNorm, StIssue} state_e;

  localparam int unsigned QDataW   = 16;
  localparam int unsigned QFracW   = 13;
  localparam int unsigned QFracExt = 8;

  // Counter/index width that never collapses to zero bits.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned sum_width(input int unsigned data_w, input int unsigned row_len);
    return data_w + idx_width(row_len);
  endfunction

endpackage

// File: rtl/softmax_div_feeder_if.sv
// Element input handshake plus the divider's two AXI-Stream inputs (divisor and dividend).
// With ROW_LAST_EN defined the interface also carries in_last.
interface softmax_div_feeder_if
  import softmax_pkg::*;
#(
  parameter int unsigned DATA_W   = QDataW,
  parameter int unsigned FRAC_EXT = QFracExt
);

  logic                       in_valid;
  logic [DATA_W-1:0]          in_data;
  logic                       in_ready;
`ifdef ROW_LAST_EN
  logic                       in_last;
`endif
  logic                       s_axis_divisor_tvalid;
  logic [DATA_W-1:0]          s_axis_divisor_tdata;
  logic                       s_axis_dividend_tvalid;
  logic [DATA_W+FRAC_EXT-1:0] s_axis_dividend_tdata;

  modport master (
`ifdef ROW_LAST_EN
    input  in_last,
`endif
    input  in_valid,
    input  in_data,
    output in_ready,
    output s_axis_divisor_tvalid,
    output s_axis_divisor_tdata,
    output s_axis_dividend_tvalid,
    output s_axis_dividend_tdata
  );

  modport slave (
`ifdef ROW_LAST_EN
    output in_last,
`endif
    output in_valid,
    output in_data,
    input  in_ready,
    input  s_axis_divisor_tvalid,
    input  s_axis_divisor_tdata,
    input  s_axis_dividend_tvalid,
    input  s_axis_dividend_tdata
  );

endinterface

// File: rtl/softmax_div_feeder_row_buf.sv
// Row buffer: one write port, one registered read port. Contents are not reset.
module softmax_row_buf #(
  parameter int unsigned ROW_LEN = 64,
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 6
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [ROW_LEN];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/softmax_div_feeder.sv
// Softmax divider feeder: buffers a row of Q2.13 exponents, normalises the row sum and streams
// one divisor/dividend pair per cycle. Define ROW_LAST_EN to allow in_last to end a row early.
module softmax_div_feeder
  import softmax_pkg::*;
#(
  parameter int unsigned ROW_LEN   = 64,
  parameter int unsigned DATA_W    = QDataW,
  parameter int unsigned FRAC_EXT  = QFracExt,
  parameter int unsigned MAX_SHIFT = 8
) (
  input  logic                              aclk,
  input  logic                              aresetn,
  softmax_div_feeder_if.master              bus,
  output logic [idx_width(ROW_LEN)-1:0]     issue_idx,
  output logic [idx_width(MAX_SHIFT+1)-1:0] shift_amt,
  output logic                              sat_flag,
  output logic                              zero_flag,
  output logic                              row_done
);

  localparam int unsigned IdxW = idx_width(ROW_LEN);
  localparam int unsigned ShW  = idx_width(MAX_SHIFT + 1);
  localparam int unsigned SumW = sum_width(DATA_W, ROW_LEN);
  localparam int unsigned DvdW = DATA_W + FRAC_EXT;
  localparam logic [SumW-1:0]   DivLimit = SumW'(1) << (DATA_W - 1);
  localparam logic [IdxW-1:0]   LastIdx  = IdxW'(ROW_LEN - 1);
  localparam logic [DATA_W-1:0] DivSat   = {1'b0, {(DATA_W - 1){1'b1}}};

  state_e            state_q;
  logic [IdxW-1:0]   cnt_q, last_q, issue_idx_q;
  logic [SumW-1:0]   sum_q;
  logic [ShW-1:0]    shift_q;
  logic [DATA_W-1:0] divisor_q, rd_data;
  logic [DvdW-1:0]   dividend_q;
  logic              in_ready_q, tvalid_q, row_done_q, sat_q, zero_q;

  logic              accept, row_end, norm_sat;
  logic [ShW-1:0]    norm_k;
  logic [DATA_W-1:0] norm_div;

  assign accept = (state_q == StLoad) && in_ready_q && bus.in_valid;
`ifdef ROW_LAST_EN
  assign row_end = (cnt_q == LastIdx) || bus.in_last;
`else
  assign row_end = (cnt_q == LastIdx);
`endif

  // Smallest shift that brings the sum below 2^(DATA_W-1); saturate if none up to MAX_SHIFT.
  always_comb begin
    norm_k   = ShW'(MAX_SHIFT);
    norm_sat = 1'b1;
    for (int k = MAX_SHIFT; k >= 0; k--) begin
      if ((sum_q >> k) < DivLimit) begin
        norm_k   = ShW'(k);
        norm_sat = 1'b0;
      end
    end
    norm_div = norm_sat ? DivSat : DATA_W'(sum_q >> norm_k);
  end

  // cnt_q is the write address in LOAD and runs one ahead of issue_idx_q as the read address.
  softmax_row_buf #(
    .ROW_LEN (ROW_LEN),
    .DATA_W  (DATA_W),
    .ADDR_W  (IdxW)
  ) u_row_buf (
    .clk_i   (aclk),
    .we_i    (accept),
    .waddr_i (cnt_q),
    .wdata_i (bus.in_data),
    .raddr_i (cnt_q),
    .rdata_o (rd_data)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= StLoad;
      cnt_q       <= '0;
      last_q      <= '0;
      issue_idx_q <= '0;
      sum_q       <= '0;
      shift_q     <= '0;
      divisor_q   <= '0;
      dividend_q  <= '0;
      in_ready_q  <= 1'b0;
      tvalid_q    <= 1'b0;
      row_done_q  <= 1'b0;
      sat_q       <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      row_done_q <= 1'b0;
      case (state_q)
        StLoad: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            sum_q <= sum_q + SumW'(bus.in_data);
            if (row_end) begin
              cnt_q      <= '0;
              last_q     <= cnt_q;
              in_ready_q <= 1'b0;
              state_q    <= StNorm;
            end else begin
              cnt_q <= cnt_q + IdxW'(1);
            end
          end
        end
        StNorm: begin
          shift_q   <= norm_k;
          sat_q     <= norm_sat;
          zero_q    <= (sum_q == '0);
          divisor_q <= norm_div;
          sum_q     <= '0;
          if (cnt_q != LastIdx) cnt_q <= cnt_q + IdxW'(1);
          state_q   <= StIssue;
        end
        StIssue: begin
          if (tvalid_q && (issue_idx_q == last_q)) begin
            tvalid_q   <= 1'b0;
            row_done_q <= 1'b1;
            in_ready_q <= 1'b1;
            cnt_q      <= '0;
            state_q    <= StLoad;
          end else begin
            tvalid_q    <= 1'b1;
            issue_idx_q <= tvalid_q ? issue_idx_q + IdxW'(1) : '0;
            dividend_q  <= {rd_data, {FRAC_EXT{1'b0}}} >> shift_q;
            if (cnt_q != LastIdx) cnt_q <= cnt_q + IdxW'(1);
          end
        end
        default: state_q <= StLoad;
      endcase
    end
  end

  assign bus.in_ready               = in_ready_q;
  assign bus.s_axis_divisor_tvalid  = tvalid_q;
  assign bus.s_axis_divisor_tdata   = divisor_q;
  assign bus.s_axis_dividend_tvalid = tvalid_q;
  assign bus.s_axis_dividend_tdata  = dividend_q;
  assign issue_idx                  = issue_idx_q;
  assign shift_amt                  = shift_q;
  assign sat_flag                   = sat_q;
  assign zero_flag                  = zero_q;
  assign row_done                   = row_done_q;

endmodule

// File: tb/tb_softmax_div_feeder.sv
// Randomised bench for softmax_div_feeder (ROW_LEN=4, MAX_SHIFT=1) against a row-level model.
module tb_softmax_div_feeder;

  localparam int unsigned RowLen   = 4;
  localparam int unsigned DataW    = 16;
  localparam int unsigned FracExt  = 8;
  localparam int unsigned MaxShift = 1;

  logic       aclk;
  logic       aresetn;
  logic [1:0] issue_idx;
  logic [0:0] shift_amt;
  logic       sat_flag, zero_flag, row_done;

  softmax_div_feeder_if #(.DATA_W(DataW), .FRAC_EXT(FracExt)) bus ();

  softmax_div_feeder #(
    .ROW_LEN   (RowLen),
    .DATA_W    (DataW),
    .FRAC_EXT  (FracExt),
    .MAX_SHIFT (MaxShift)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .bus       (bus),
    .issue_idx (issue_idx),
    .shift_amt (shift_amt),
    .sat_flag  (sat_flag),
    .zero_flag (zero_flag),
    .row_done  (row_done)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int unsigned vec_cnt = 0;
  int unsigned err_cnt = 0;
  int unsigned cyc = 0;

  logic [15:0] row_vals [RowLen];
  logic [1:0]  mon_idx [$];
  logic [15:0] mon_div [$];
  logic [23:0] mon_dvd [$];
  int unsigned mon_first_cyc = 0;
  int unsigned done_cnt = 0;
  int unsigned done_cyc = 0;
  int unsigned pair_bad = 0;
  int unsigned acc_first_cyc = 0;
  int unsigned acc_last_cyc = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
    #1;
  endtask

  initial forever begin
    @(posedge aclk);
    cyc++;
  end

  // Output monitor samples on the falling edge, one time step before the stimulus thread.
  initial forever begin
    @(negedge aclk);
    if (bus.s_axis_divisor_tvalid !== bus.s_axis_dividend_tvalid) pair_bad++;
    if (bus.s_axis_divisor_tvalid === 1'b1) begin
      if (mon_idx.size() == 0) mon_first_cyc = cyc;
      mon_idx.push_back(issue_idx);
      mon_div.push_back(bus.s_axis_divisor_tdata);
      mon_dvd.push_back(bus.s_axis_dividend_tdata);
    end
    if (row_done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic send_row(input int len, input bit keep);
    for (int i = 0; i < len; i++) begin
      int guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = row_vals[i];
`ifdef ROW_LAST_EN
      bus.in_last  = (i == len - 1);
`endif
      while (bus.in_ready !== 1'b1 && guard < 50) begin
        tick();
        guard++;
      end
      check_eq("in_ready_wait", bus.in_ready, 1);
      if (i == 0) acc_first_cyc = cyc;
      acc_last_cyc = cyc;
      tick();
    end
    if (!keep) begin
      bus.in_valid = 1'b0;
`ifdef ROW_LAST_EN
      bus.in_last  = 1'b0;
`endif
    end
  endtask

  task automatic run_row(input string tag, input int len, input bit keep);
    int unsigned prev_done;
    int guard, sum, k;
    bit sat;
    logic [15:0] div;
    mon_idx.delete();
    mon_div.delete();
    mon_dvd.delete();
    pair_bad  = 0;
    prev_done = done_cnt;
    send_row(len, keep);
    guard = 0;
    while (done_cnt == prev_done && guard < 40) begin
      tick();
      guard++;
    end
    check_eq({tag, ".row_done"}, done_cnt - prev_done, 1);
    sum = 0;
    for (int i = 0; i < len; i++) sum += int'(row_vals[i]);
    k = 0;
    while (k <= int'(MaxShift) && (sum >> k) >= 32768) k++;
    sat = (k > int'(MaxShift));
    if (sat) begin
      k   = MaxShift;
      div = 16'h7FFF;
    end else begin
      div = 16'(sum >> k);
    end
    check_eq({tag, ".issues"}, mon_idx.size(), len);
    for (int i = 0; i < len && i < mon_idx.size(); i++) begin
      check_eq({tag, ".idx"}, mon_idx[i], i);
      check_eq({tag, ".divisor"}, mon_div[i], div);
      check_eq({tag, ".dividend"}, mon_dvd[i], (int'(row_vals[i]) * 256) >> k);
    end
    check_eq({tag, ".shift_amt"}, shift_amt, k);
    check_eq({tag, ".sat_flag"}, sat_flag, sat);
    check_eq({tag, ".zero_flag"}, zero_flag, sum == 0);
    check_eq({tag, ".tvalid_pair"}, pair_bad, 0);
    check_eq({tag, ".first_lat"}, mon_first_cyc - acc_last_cyc, 3);
    check_eq({tag, ".done_lat"}, done_cyc - acc_last_cyc, 3 + len);
  endtask

  initial begin
    int unsigned d1, a1, n_before, d_before;
    int guard, hi, len;
    aresetn      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
`ifdef ROW_LAST_EN
    bus.in_last  = 1'b0;
`endif
    repeat (3) tick();
    check_eq("rst.in_ready", bus.in_ready, 0);
    check_eq("rst.div_tvalid", bus.s_axis_divisor_tvalid, 0);
    check_eq("rst.dvd_tvalid", bus.s_axis_dividend_tvalid, 0);
    check_eq("rst.div_tdata", bus.s_axis_divisor_tdata, 0);
    check_eq("rst.dvd_tdata", bus.s_axis_dividend_tdata, 0);
    check_eq("rst.outs", {issue_idx, shift_amt, sat_flag, zero_flag, row_done}, 0);
    aresetn = 1'b1;
    check_eq("rel.in_ready_low", bus.in_ready, 0);
    tick();
    check_eq("rel.in_ready_high", bus.in_ready, 1);

    for (int i = 0; i < RowLen; i++) row_vals[i] = 16'h0800;
    run_row("r0800", RowLen, 1'b0);
    for (int i = 0; i < RowLen; i++) row_vals[i] = 16'h2000;
    run_row("r2000", RowLen, 1'b0);
    for (int i = 0; i < RowLen; i++) row_vals[i] = 16'h0000;
    run_row("rzero", RowLen, 1'b0);
    for (int i = 0; i < RowLen; i++) row_vals[i] = 16'h7FFF;
    run_row("rsat", RowLen, 1'b0);

    // in_valid held high across two back-to-back rows.
    for (int i = 0; i < RowLen; i++) row_vals[i] = 16'($urandom_range(0, 16'h3FFF));
    run_row("hold1", RowLen, 1'b1);
    d1 = done_cyc;
    a1 = acc_last_cyc;
    for (int i = 0; i < RowLen; i++) row_vals[i] = 16'($urandom_range(0, 16'h3FFF));
    run_row("hold2", RowLen, 1'b0);
    check_eq("hold.start_on_done", acc_first_cyc, d1);
    check_eq("hold.accept_gap", acc_first_cyc - a1, 3 + RowLen);

    // Asynchronous reset in the middle of ISSUE.
    for (int i = 0; i < RowLen; i++) row_vals[i] = 16'($urandom_range(1, 16'h1FFF));
    mon_idx.delete();
    mon_div.delete();
    mon_dvd.delete();
    send_row(RowLen, 1'b0);
    guard = 0;
    while (mon_idx.size() < 2 && guard < 20) begin
      tick();
      guard++;
    end
    check_eq("mid.issuing", bus.s_axis_divisor_tvalid, 1);
    aresetn = 1'b0;
    #1;
    check_eq("mid.div_tvalid", bus.s_axis_divisor_tvalid, 0);
    check_eq("mid.dvd_tvalid", bus.s_axis_dividend_tvalid, 0);
    check_eq("mid.in_ready", bus.in_ready, 0);
    check_eq("mid.outs", {issue_idx, shift_amt, sat_flag, zero_flag, row_done}, 0);
    n_before = mon_idx.size();
    d_before = done_cnt;
    repeat (3) tick();
    aresetn = 1'b1;
    check_eq("mid.rel_ready_low", bus.in_ready, 0);
    tick();
    check_eq("mid.rel_ready_high", bus.in_ready, 1);
    repeat (8) tick();
    check_eq("mid.no_more_issue", mon_idx.size(), n_before);
    check_eq("mid.no_row_done", done_cnt, d_before);
    for (int i = 0; i < RowLen; i++) row_vals[i] = 16'h0800;
    run_row("post_rst", RowLen, 1'b0);

`ifdef ROW_LAST_EN
    for (int i = 0; i < RowLen; i++) row_vals[i] = 16'h1000;
    run_row("last3", 3, 1'b0);
`endif

    for (int r = 0; r < 16; r++) begin
      case ($urandom_range(0, 3))
        0:       hi = 16'h00FF;
        1:       hi = 16'h1FFF;
        2:       hi = 16'h3FFF;
        default: hi = 16'h7FFF;
      endcase
      for (int i = 0; i < RowLen; i++) row_vals[i] = 16'($urandom_range(0, hi));
      len = RowLen;
`ifdef ROW_LAST_EN
      len = $urandom_range(1, RowLen);
`endif
      run_row("rand", len, 1'($urandom_range(0, 1)));
    end
    bus.in_valid = 1'b0;
    repeat (2) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/softmax_div_feeder.md
Name: softmax_div_feeder

Overview:
- Upstream feeder for the 16-bit / 8-fraction-bit divider IP in the softmax path of the MHA datapath.
- Accepts one row of non-negative exponent values in Q2.13 (1 sign, 2 integer, 13 fraction bits), buffers them and accumulates the row sum.
- Normalises the sum and the dividends by a common right shift so the divisor fits 16-bit signed.
- Then issues one divisor/dividend pair per cycle on the divider's AXI-Stream inputs. The divider has no tready, so the feeder never stalls once issuing.

Parameters:
- ROW_LEN, 64, number of elements per row; buffer depth.
- DATA_W, 16, width of input elements and of the divisor.
- FRAC_EXT, 8, extra fraction bits appended to the dividend; dividend width is DATA_W+FRAC_EXT = 24.
- MAX_SHIFT, 8, largest normalisation shift allowed; MAX_SHIFT <= FRAC_EXT.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  reset, asynchronous, active-low.
- in_valid  in  1  input element valid.
- in_data  in  DATA_W  exponent value, Q2.13, bit 15 expected 0.
- in_ready  out  1  feeder can accept an element.
- s_axis_divisor_tvalid  out  1  divisor valid to the divider.
- s_axis_divisor_tdata  out  DATA_W  normalised row sum.
- s_axis_dividend_tvalid  out  1  dividend valid to the divider.
- s_axis_dividend_tdata  out  DATA_W+FRAC_EXT  normalised element.
- issue_idx  out  clog2(ROW_LEN)  index of the element being issued.
- shift_amt  out  clog2(MAX_SHIFT+1)  normalisation shift of the current row.
- sat_flag  out  1  sum needed more than MAX_SHIFT; divisor saturated.
- zero_flag  out  1  row sum is zero.
- row_done  out  1  one-cycle pulse on the cycle after the last issue.

Behaviour:
- Reset: all outputs 0 except in_ready = 0; in_ready rises on the first clock after reset release. Sum, counters and flags are cleared; buffer contents are don't-care. Reset asserted mid-row aborts the row with no further issues.
- FSM states: LOAD, NORM, ISSUE.
- LOAD:
  - in_ready = 1.
  - Each in_valid&in_ready handshake writes buf[cnt] and adds in_data to a sum of width DATA_W+clog2(ROW_LEN).
  - On the ROW_LEN-th handshake go to NORM; in_ready drops the next cycle.
- NORM (one cycle):
  - k = smallest value in 0..MAX_SHIFT with (sum>>k) < 2^(DATA_W-1).
  - If no such k exists: k = MAX_SHIFT, divisor = 2^(DATA_W-1)-1, sat_flag = 1.
  - zero_flag = (sum == 0).
  - shift_amt = k; the divisor register is loaded; go to ISSUE.
- ISSUE:
  - For i = 0..ROW_LEN-1, one per cycle: both tvalids = 1, divisor tdata = (sum>>k) truncated, held constant for the row; dividend tdata = {buf[i], FRAC_EXT'b0} >> k; issue_idx = i.
  - The two tvalids are always asserted together.
  - Zero sum still issues with divisor 0; the divider's divide-by-zero output is the consumer's concern.
  - After i = ROW_LEN-1: tvalids drop, row_done pulses, return to LOAD.
  - shift_amt and the flags hold until the next NORM.
- Latency: first issue is 2 clocks after the clock edge that accepts the last element. One row occupies 2+ROW_LEN cycles from the last handshake until the next element is accepted.
- in_valid during NORM/ISSUE is ignored (in_ready = 0). A new row may start on the cycle row_done is high.
- All outputs are registered.

Optional Feature:
- Macro ROW_LAST_EN.
- Defined: adds input port in_last (1 bit). A handshake with in_last = 1 ends the row early; the row length is L = cnt+1 <= ROW_LEN, and exactly L pairs are issued. Reaching ROW_LEN also ends the row.
- Undefined: rows are fixed at ROW_LEN; no in_last port.

Decomposition:
- Package softmax_pkg holds: the state enum, the Q2.13 format constants (DATA_W, FRAC bits), and a localparam function for the sum width.
- Sub-module softmax_row_buf: a ROW_LEN x DATA_W register buffer with one write port and one synchronous read port, read address = issue counter. All other logic stays in the feeder.

Test Plan:
- ROW_LEN=4, inputs 0x0800 x4 -> sum 0x2000, shift_amt 0, divisor 0x2000, dividends 0x080000 x4, issue_idx 0..3, row_done 1 cycle later.
- ROW_LEN=4, inputs 0x2000 x4 -> sum 0x8000, shift_amt 1, divisor 0x4000, dividends 0x100000.
- ROW_LEN=4, inputs all 0 -> zero_flag 1, divisor 0x0000, 4 issues, sat_flag 0.
- MAX_SHIFT=0, ROW_LEN=4, inputs 0x2000 x4 -> sat_flag 1, divisor 0x7FFF, dividends 0x200000.
- in_valid held high through a row -> exactly 4 accepts, in_ready low for 2+4 cycles, the next row starts on the row_done cycle. Reset pulse during ISSUE -> tvalids 0 immediately (asynchronous), no row_done.
- ROW_LAST_EN defined, in_last on the 3rd element (0x1000 each) -> sum 0x3000, 3 issues only, issue_idx 0..2.
